// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the key conditioner.
// Optional long-press support is enabled by defining KEY_CONDITIONER_LONG_PRESS_EN.
package key_cond_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 50000000;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Counter only has to reach LONG_CYCLES when long-press detection is built in.
    function automatic int unsigned cnt_width(input int unsigned debounce,
                                              input int unsigned long_cycles);
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
        cnt_width = $clog2(long_cycles + 1);
`else
        cnt_width = (long_cycles > debounce) ? $clog2(debounce + 1) : $clog2(debounce + 1);
`endif
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and counter.
// Long-press pulse exists only when KEY_CONDITIONER_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    ,
    output logic long_pulse
`endif
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
`endif

    logic [1:0]    sync_q;
    logic          pressed;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    logic          long_q, long_d;
    logic          long_done_q, long_done_d;
`endif

    // Synchronize the raw active-low input; reset value is "released".
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], key_n};
    end

    assign pressed = ~sync_q[1];

    // Next-state logic: pulses are decided here and registered below.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
        long_d      = 1'b0;
        long_done_d = long_done_q;
`endif
        case (state_q)
            S_RELEASED: begin
                if (pressed) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
                    long_done_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!pressed) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
                // Held count saturates at LONG_CYCLES; long_done blocks a second pulse.
                else if (cnt_q != LONG_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LONG_LAST && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
`endif
            end
            S_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = S_PRESSED;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
                    cnt_d = CW'(1); // the returning sample already counts as held
`else
                    cnt_d = '0;
`endif
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = S_RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
            long_q      <= 1'b0;
            long_done_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
            long_q      <= long_d;
            long_done_q <= long_done_d;
`endif
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    assign long_pulse = long_q;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Debounces NKEYS active-low push buttons into level and press/release pulses.
// Define KEY_CONDITIONER_LONG_PRESS_EN to add the o_key_long output.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned NKEYS           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NKEYS-1:0] i_key_n,
    output logic [NKEYS-1:0] o_key_level,
    output logic [NKEYS-1:0] o_key_press,
    output logic [NKEYS-1:0] o_key_release
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    ,
    output logic [NKEYS-1:0] o_key_long
`endif
);

    for (genvar g = 0; g < NKEYS; g++) begin : gen_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk          (i_clk),
            .rst          (i_rst),
            .key_n        (i_key_n[g]),
            .level        (o_key_level[g]),
            .press_pulse  (o_key_press[g]),
            .release_pulse(o_key_release[g])
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
            ,
            .long_pulse   (o_key_long[g])
`endif
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Long-press checks are compiled in when KEY_CONDITIONER_LONG_PRESS_EN is defined.
module tb_key_conditioner;

    localparam int unsigned NK   = 3;
    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] level, press, rel;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    logic [NK-1:0] lng;
`endif

    always #5 clk = ~clk;

    key_conditioner #(
        .NKEYS          (NK),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_key_n      (key_n),
        .o_key_level  (level),
        .o_key_press  (press),
        .o_key_release(rel)
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
        ,
        .o_key_long   (lng)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Reference model: an accepted level flips once DEB+1 consecutive samples
    // (as seen two edges after the raw pin) disagree with it.
    bit            m_s1 [NK];
    bit            m_s2 [NK];
    bit            m_lvl [NK];
    int            m_run [NK];
    int            m_hold [NK];
    bit            m_done [NK];
    logic [NK-1:0] m_level, m_press, m_rel, m_long;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge(input logic [NK-1:0] raw, input logic r);
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int ch = 0; ch < NK; ch++) begin
            if (r) begin
                m_s1[ch] = 1'b1; m_s2[ch] = 1'b1; m_lvl[ch] = 1'b0;
                m_run[ch] = 0; m_hold[ch] = 0; m_done[ch] = 1'b0;
            end else begin
                bit pr;
                pr = !m_s2[ch];
                if (pr != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_lvl[ch]) m_hold[ch] = 0;
                    if (m_run[ch] == DEB + 1) begin
                        m_lvl[ch] = pr;
                        m_run[ch] = 0;
                        if (pr) begin
                            m_press[ch] = 1'b1;
                            m_hold[ch]  = 0;
                            m_done[ch]  = 1'b0;
                        end else begin
                            m_rel[ch] = 1'b1;
                        end
                    end
                end else begin
                    m_run[ch] = 0;
                    if (pr) begin
                        m_hold[ch]++;
                        if (m_hold[ch] == LONG && !m_done[ch]) begin
                            m_long[ch] = 1'b1;
                            m_done[ch] = 1'b1;
                        end
                    end
                end
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = raw[ch];
            end
            m_level[ch] = m_lvl[ch];
        end
    endtask

    // Drive one clock edge, advance the model, compare all outputs.
    task automatic tick(input logic [NK-1:0] raw, input logic r);
        key_n = raw;
        rst   = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
        check("level", 32'(level), 32'(m_level));
        check("press", 32'(press), 32'(m_press));
        check("release", 32'(rel), 32'(m_rel));
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
        check("long", 32'(lng), 32'(m_long));
`endif
    endtask

    // Hold raw for n edges; report index of first pulse of kind (0 press, 1 release, 2 long).
    task automatic hold_watch(input logic [NK-1:0] raw, input int n, input int ch,
                              input int kind, output int first, output int cnt,
                              output logic [NK-1:0] vec, output logic lvl);
        logic [NK-1:0] sel;
        first = -1;
        cnt   = 0;
        vec   = '0;
        lvl   = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(raw, 1'b0);
            sel = (kind == 0) ? press : (kind == 1) ? rel : '0;
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
            if (kind == 2) sel = lng;
`endif
            if (sel[ch]) begin
                if (first < 0) begin
                    first = i;
                    vec   = sel;
                    lvl   = level[ch];
                end
                cnt++;
            end
        end
    endtask

    initial begin
        int            first, cnt, early;
        logic [NK-1:0] vec, cur;
        logic          lvl;
        int            rem [NK];

        key_n = '1;
        rst   = 1'b1;
        tick('1, 1'b1);
        tick('1, 1'b1);
        check("rst_outputs", 32'({level, press, rel}), 32'd0);
        for (int i = 0; i < 6; i++) tick('1, 1'b0);

        // Clean press on key0, then clean release.
        hold_watch(3'b110, 12, 0, 0, first, cnt, vec, lvl);
        check("clean_press_edge", 32'(first), 32'd6);
        check("clean_press_count", 32'(cnt), 32'd1);
        check("clean_press_level", 32'(lvl), 32'd1);
        hold_watch(3'b111, 12, 0, 1, first, cnt, vec, lvl);
        check("key0_release_edge", 32'(first), 32'd6);

        // Bounce on key1: low 3, high 1, then held low.
        early = 0;
        for (int i = 0; i < 3; i++) begin tick(3'b101, 1'b0); early += int'(press[1]); end
        tick(3'b111, 1'b0);
        early += int'(press[1]);
        check("bounce_early", 32'(early), 32'd0);
        hold_watch(3'b101, 12, 1, 0, first, cnt, vec, lvl);
        check("bounce_press_edge", 32'(first), 32'd6);
        check("bounce_press_count", 32'(cnt), 32'd1);
        hold_watch(3'b111, 12, 1, 1, first, cnt, vec, lvl);

        // Key2 press then clean release.
        hold_watch(3'b011, 12, 2, 0, first, cnt, vec, lvl);
        hold_watch(3'b111, 12, 2, 1, first, cnt, vec, lvl);
        check("release_edge", 32'(first), 32'd6);
        check("release_count", 32'(cnt), 32'd1);
        check("release_level", 32'(lvl), 32'd0);

        // Keys 0 and 2 together.
        hold_watch(3'b010, 12, 0, 0, first, cnt, vec, lvl);
        check("simul_press_vec", 32'(vec), 32'b101);
        check("simul_press_edge", 32'(first), 32'd6);
        hold_watch(3'b111, 12, 0, 1, first, cnt, vec, lvl);
        check("simul_release_vec", 32'(vec), 32'b101);

        // Reset while key0 is mid-debounce, key stays held.
        for (int i = 0; i < 6; i++) tick(3'b110, 1'b0);
        tick(3'b110, 1'b1);
        check("rst_mid_outputs", 32'({level, press, rel}), 32'd0);
        hold_watch(3'b110, 12, 0, 0, first, cnt, vec, lvl);
        check("rst_mid_fresh_edge", 32'(first), 32'd6);
        check("rst_mid_fresh_count", 32'(cnt), 32'd1);
        hold_watch(3'b111, 12, 0, 1, first, cnt, vec, lvl);

`ifdef KEY_CONDITIONER_LONG_PRESS_EN
        // Long hold on key0: one long pulse LONG samples after acceptance.
        hold_watch(3'b110, 40, 0, 2, first, cnt, vec, lvl);
        check("long_edge", 32'(first), 32'(6 + LONG));
        check("long_count", 32'(cnt), 32'd1);
        hold_watch(3'b111, 12, 0, 1, first, cnt, vec, lvl);
`endif

        // Random per-key hold lengths with occasional reset.
        cur = '1;
        for (int ch = 0; ch < NK; ch++) rem[ch] = 0;
        for (int i = 0; i < 1200; i++) begin
            for (int ch = 0; ch < NK; ch++) begin
                if (rem[ch] == 0) begin
                    cur[ch] = 1'($urandom_range(0, 1));
                    rem[ch] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 35))
                                                          : int'($urandom_range(1, 9));
                end
                rem[ch]--;
            end
            tick(cur, ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
